// File: rtl/vram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Bus bundle between the display fetch engine, the CPU bus
//               requester, the display RAM macro and vram_arbiter.
//               Video side : vid_req, vid_addr -> vid_data
//               CPU side   : cpu_req/we/addr/wdata -> cpu_ack, cpu_rdata
//               RAM side   : ram_addr/we/wdata <- ram_rdata
//               Status     : starve
//               slave  = arbiter view, master = requesters + RAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = 8
);
  logic                 vid_req;
  logic [ADDR_BITS-1:0] vid_addr;
  logic [DATA_BITS-1:0] vid_data;

  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [DATA_BITS-1:0] cpu_wdata;
  logic                 cpu_ack;
  logic [DATA_BITS-1:0] cpu_rdata;

  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_we;
  logic [DATA_BITS-1:0] ram_wdata;
  logic [DATA_BITS-1:0] ram_rdata;

  logic                 starve;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata, starve
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata, starve
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one single-port synchronous display RAM between the
//               pixel fetch engine (absolute priority, fixed 2-cycle latency)
//               and a CPU req/ack requester that gets every free cycle.
//               A sticky starve flag reports CPU requests denied too long.
// Ports       : clk_pixel - pixel clock, all logic on the rising edge
//               reset_n   - asynchronous active-low reset
//               bus       - vram_arbiter_if.slave (video, CPU, RAM, starve)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_BITS    = 13,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic           clk_pixel,
  input  logic           reset_n,
  vram_arbiter_if.slave  bus
);

  localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] c_CNT_MAX      = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_cpu_grant;
  logic                 w_cpu_denied;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic                 w_ram_we;
  logic [7:0]           w_cnt_next;

  logic                 r_vpend;
  logic [DATA_BITS-1:0] r_vid_data;
  logic [DATA_BITS-1:0] r_cpu_rdata;
  logic [7:0]           r_cnt;
  logic                 r_starve;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state, grant decision and RAM port steering.
  // The CPU can only be granted from IDLE and only when video leaves the
  // port free; a video read may share the RD_WAIT and ACK cycles because
  // the CPU does not drive the port there.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cpu_grant  = 1'b0;
    w_cpu_denied = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          if (bus.vid_req) begin
            w_cpu_denied = 1'b1;
          end else begin
            w_cpu_grant  = 1'b1;
            w_state_next = bus.cpu_we ? S_ACK : S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: w_state_next = S_ACK;
      S_ACK:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase

    // Idle port parks on the video address so a late video strobe costs nothing.
    w_ram_addr = bus.vid_addr;
    w_ram_we   = 1'b0;
    if (w_cpu_grant) begin
      w_ram_addr = bus.cpu_addr;
      w_ram_we   = bus.cpu_we;
    end

    // Starve counter: cleared on grant or when nobody is asking, saturating.
    w_cnt_next = r_cnt;
    if (w_cpu_grant || ((r_state == S_IDLE) && !bus.cpu_req)) begin
      w_cnt_next = 8'd0;
    end else if (w_cpu_denied && (r_cnt != c_CNT_MAX)) begin
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: video pipeline, CPU read capture, starvation monitor
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_vpend     <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
      r_cnt       <= 8'd0;
      r_starve    <= 1'b0;
    end else begin
      // RAM data arrives one cycle after the address, so the flag marks the
      // cycle in which ram_rdata belongs to the video fetch.
      r_vpend <= bus.vid_req;
      if (r_vpend) begin
        r_vid_data <= bus.ram_rdata;
      end
      if (r_state == S_RD_WAIT) begin
        r_cpu_rdata <= bus.ram_rdata;
      end
      r_cnt <= w_cnt_next;
      // Set on the same edge the counter reaches the limit; sticky until reset.
      if (w_cnt_next == c_STARVE_LIMIT) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_we    = w_ram_we;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.vid_data  = r_vid_data;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = (r_state == S_ACK);
  assign bus.starve    = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Self-checking bench for vram_arbiter with a behavioural RAM
//               macro and a shadow memory holding the expected contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LIMIT = 64;
  localparam int DEPTH = 1 << AW;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  vram_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus();

  vram_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:DEPTH-1];
  logic [7:0] exp_vid = 8'h00;

  function automatic logic [7:0] seed_byte(int i);
    return 8'((i * 37) ^ (i >> 3) ^ 8'hA7);
  endfunction

  // RAM macro: synchronous, read data one cycle after the address
  logic [7:0] ram [0:DEPTH-1];
  logic [7:0] ram_q;
  logic       init_mem = 1'b0;
  always @(posedge clk_pixel) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed_byte(i);
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
    ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  // Requester protocol: cpu_req must stay high until cpu_ack
  logic req_open;
  always @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      req_open <= 1'b0;
    end else begin
      assert (!(req_open && !bus.cpu_req && !bus.cpu_ack))
        else $error("FAIL protocol: cpu_req dropped before cpu_ack");
      if (bus.cpu_ack) req_open <= 1'b0;
      else if (bus.cpu_req) req_open <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    checks++; if (bus.vid_data !== 8'h00) begin errors++; $display("FAIL rst_vid_data got %h want 00", bus.vid_data); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata got %h want 00", bus.cpu_rdata); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack got %b want 0", bus.cpu_ack); end
    checks++; if (bus.starve !== 1'b0) begin errors++; $display("FAIL rst_starve got %b want 0", bus.starve); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", bus.ram_we); end
    reset_n = 1'b1;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_video();
    bit         have_prev;
    bit         vr;
    logic [7:0] prev_val, cur_val;
    logic [12:0] va;
    // place 0xA5 at address 5 through the CPU port
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0005; bus.cpu_wdata = 8'hA5;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    ref_mem[5] = 8'hA5;

    bus.vid_req = 1'b1; bus.vid_addr = 13'h0005;
    #1;
    checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 13'h0005) begin
      errors++; $display("FAIL vid_port we=%b addr=%h want 0 0005", bus.ram_we, bus.ram_addr); end
    tick();
    bus.vid_req = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL vid_we got %b want 0", bus.ram_we); end
    tick();
    checks++; if (bus.vid_data !== 8'hA5) begin errors++; $display("FAIL vid_first got %h want a5", bus.vid_data); end
    exp_vid = 8'hA5;
    tick();
    checks++; if (bus.vid_data !== exp_vid) begin errors++; $display("FAIL vid_hold got %h want %h", bus.vid_data, exp_vid); end

    have_prev = 1'b0; prev_val = 8'h00;
    for (int k = 0; k < 64; k++) begin
      vr = ($urandom % 2) == 1;
      va = 13'($urandom);
      bus.vid_req = vr; bus.vid_addr = va;
      cur_val = ref_mem[va];
      #1;
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL vid_rand_we k=%0d got %b want 0", k, bus.ram_we); end
      tick();
      if (have_prev) exp_vid = prev_val;
      checks++; if (bus.vid_data !== exp_vid) begin
        errors++; $display("FAIL vid_stream k=%0d got %h want %h", k, bus.vid_data, exp_vid); end
      have_prev = vr; prev_val = cur_val;
    end
    bus.vid_req = 1'b0;
    tick();
    if (have_prev) exp_vid = prev_val;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_cpu_write_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_wdata = 8'h3C;
    #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 13'h1FFF || bus.ram_wdata !== 8'h3C) begin
      errors++; $display("FAIL wr_grant we=%b addr=%h wdata=%h want 1 1fff 3c", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack got %b want 0", bus.cpu_ack); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", bus.cpu_ack); end
    ref_mem[13'h1FFF] = 8'h3C;
    bus.cpu_req = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL wr_ack_we got %b want 0", bus.ram_we); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_len got %b want 0", bus.cpu_ack); end
    checks++; if (ram[13'h1FFF] !== 8'h3C) begin errors++; $display("FAIL wr_ram got %h want 3c", ram[13'h1FFF]); end

    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 13'h1FFF) begin
      errors++; $display("FAIL rd_grant we=%b addr=%h want 0 1fff", bus.ram_we, bus.ram_addr); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_wait_ack got %b want 0", bus.cpu_ack); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL rd_ack ack=%b rdata=%h want 1 3c", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
    checks++; if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL rd_hold ack=%b rdata=%h want 0 3c", bus.cpu_ack, bus.cpu_rdata); end
  endtask

  // --------------------------------------------------------------------------
  // Random CPU traffic against a video strobe every 8th cycle plus random
  // extra strobes. Expected grant = first video-free cycle after the request
  // is raised; ack follows 1 (write) or 2 (read) cycles later.
  task automatic test_cpu_with_video();
    bit          active, drop, vr, have_prev, exp_we, exp_ack;
    int          start_k, g, ack_k, started, acks;
    logic        w;
    logic [12:0] a, va;
    logic [7:0]  d, exp_rd, prev_val, cur_val;
    active = 1'b0; drop = 1'b0; have_prev = 1'b0; prev_val = 8'h00;
    g = -1; ack_k = -1; start_k = 0; started = 0; acks = 0;
    w = 1'b0; a = '0; d = '0; exp_rd = '0;
    for (int k = 0; k < 300; k++) begin
      vr = (k < 296) && (((k % 8) == 0) || ($urandom_range(0, 4) == 0));
      va = 13'($urandom);
      if (!active && !drop && (k < 270) && ($urandom_range(0, 2) != 0)) begin
        active = 1'b1; start_k = k; g = -1; started++;
        w = ($urandom % 2) == 1; a = 13'($urandom); d = 8'($urandom);
      end
      drop = 1'b0;
      bus.vid_req = vr; bus.vid_addr = va;
      bus.cpu_req = active; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
      cur_val = ref_mem[va];
      if (active && (g < 0) && !vr) begin
        g = k;
        ack_k = w ? k : k + 1;
        if (w) ref_mem[a] = d;
        else   exp_rd = ref_mem[a];
      end
      #1;
      exp_we = (g == k) && w;
      checks++; if (bus.ram_we !== exp_we) begin
        errors++; $display("FAIL mix_we k=%0d got %b want %b", k, bus.ram_we, exp_we); end
      if (vr) begin
        checks++; if (bus.ram_addr !== va) begin
          errors++; $display("FAIL mix_vaddr k=%0d got %h want %h", k, bus.ram_addr, va); end
      end else if (g == k) begin
        checks++; if (bus.ram_addr !== a) begin
          errors++; $display("FAIL mix_caddr k=%0d got %h want %h", k, bus.ram_addr, a); end
      end
      tick();
      exp_ack = active && (g >= 0) && (k == ack_k);
      checks++; if (bus.cpu_ack !== exp_ack) begin
        errors++; $display("FAIL mix_ack k=%0d got %b want %b", k, bus.cpu_ack, exp_ack); end
      if (exp_ack) begin
        acks++;
        if (!w) begin
          checks++; if (bus.cpu_rdata !== exp_rd) begin
            errors++; $display("FAIL mix_rdata k=%0d got %h want %h", k, bus.cpu_rdata, exp_rd); end
        end
        active = 1'b0; drop = 1'b1;
      end
      if (active && (k - start_k > 40)) begin
        errors++; checks++;
        $display("FAIL mix_timeout k=%0d got no ack want ack within 40 cycles", k);
        idle_inputs();
        return;
      end
      if (have_prev) exp_vid = prev_val;
      checks++; if (bus.vid_data !== exp_vid) begin
        errors++; $display("FAIL mix_vid k=%0d got %h want %h", k, bus.vid_data, exp_vid); end
      have_prev = vr; prev_val = cur_val;
    end
    checks++; if (acks !== started) begin
      errors++; $display("FAIL mix_ack_count got %0d want %0d", acks, started); end
    idle_inputs();
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0100; bus.cpu_wdata = 8'h11;
    tick();
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_w1_ack got %b want 1", bus.cpu_ack); end
    bus.cpu_addr = 13'h0101; bus.cpu_wdata = 8'hEE;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL b2b_no_regrant got %b want 0", bus.ram_we); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap_ack got %b want 0", bus.cpu_ack); end
    #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 13'h0101) begin
      errors++; $display("FAIL b2b_w2_grant we=%b addr=%h want 1 0101", bus.ram_we, bus.ram_addr); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_w2_ack got %b want 1", bus.cpu_ack); end
    ref_mem[13'h0100] = 8'h11; ref_mem[13'h0101] = 8'hEE;
    bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
    tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_r1_early got %b want 0", bus.cpu_ack); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h11) begin
      errors++; $display("FAIL b2b_r1 ack=%b rdata=%h want 1 11", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_addr = 13'h0101;
    tick(); tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'hEE) begin
      errors++; $display("FAIL b2b_r2 ack=%b rdata=%h want 1 ee", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [12:0] x, y;
    logic [7:0]  o, d;
    x = 13'h0ABC; y = 13'h0123;
    o = ref_mem[x]; d = ~o;
    bus.vid_req = 1'b1; bus.vid_addr = y;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = x; bus.cpu_wdata = d;
    #1;
    checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== y) begin
      errors++; $display("FAIL sim_port we=%b addr=%h want 0 %h", bus.ram_we, bus.ram_addr, y); end
    tick();
    checks++; if (ram[x] !== o) begin errors++; $display("FAIL sim_ram_untouched got %h want %h", ram[x], o); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL sim_ack_early got %b want 0", bus.cpu_ack); end
    bus.vid_req = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== x) begin
      errors++; $display("FAIL sim_deferred we=%b addr=%h want 1 %h", bus.ram_we, bus.ram_addr, x); end
    tick();
    checks++; if (bus.cpu_ack !== 1'b1 || ram[x] !== d) begin
      errors++; $display("FAIL sim_write ack=%b ram=%h want 1 %h", bus.cpu_ack, ram[x], d); end
    exp_vid = ref_mem[y];
    checks++; if (bus.vid_data !== exp_vid) begin
      errors++; $display("FAIL sim_vid got %h want %h", bus.vid_data, exp_vid); end
    ref_mem[x] = d;
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== d) begin
      errors++; $display("FAIL sim_readback ack=%b rdata=%h want 1 %h", bus.cpu_ack, bus.cpu_rdata, d); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0010;
    tick();
    bus.vid_req = 1'b0;
    tick();
    exp_vid = ref_mem[13'h0010];
    checks++; if (bus.vid_data !== exp_vid) begin
      errors++; $display("FAIL rm_vid_pre got %h want %h", bus.vid_data, exp_vid); end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0100;
    tick();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.vid_data !== 8'h00 || bus.cpu_rdata !== 8'h00 || bus.cpu_ack !== 1'b0 || bus.starve !== 1'b0) begin
      errors++; $display("FAIL rm_async vid=%h rdata=%h ack=%b starve=%b want 00 00 0 0",
                         bus.vid_data, bus.cpu_rdata, bus.cpu_ack, bus.starve); end
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rm_no_ack i=%0d got %b want 0", i, bus.cpu_ack); end
    end
    reset_n = 1'b1;
    exp_vid = 8'h00;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0042; bus.cpu_wdata = 8'h99;
    tick();
    checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL rm_new_wr got %b want 1", bus.cpu_ack); end
    ref_mem[13'h0042] = 8'h99;
    bus.cpu_req = 1'b0;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h99) begin
      errors++; $display("FAIL rm_new_rd ack=%b rdata=%h want 1 99", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_starve();
    logic exp_st;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0777;
    bus.vid_req = 1'b1;
    for (int k = 0; k < 70; k++) begin
      bus.vid_addr = 13'($urandom);
      tick();
      exp_st = (k + 1) >= LIMIT;
      checks++; if (bus.starve !== exp_st) begin
        errors++; $display("FAIL starve_denial n=%0d got %b want %b", k + 1, bus.starve, exp_st); end
      checks++; if (bus.cpu_ack !== 1'b0) begin
        errors++; $display("FAIL starve_ack n=%0d got %b want 0", k + 1, bus.cpu_ack); end
    end
    bus.vid_req = 1'b0;
    #1;
    checks++; if (bus.ram_addr !== 13'h0777 || bus.ram_we !== 1'b0) begin
      errors++; $display("FAIL starve_grant addr=%h we=%b want 0777 0", bus.ram_addr, bus.ram_we); end
    tick(); tick();
    checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== ref_mem[13'h0777]) begin
      errors++; $display("FAIL starve_complete ack=%b rdata=%h want 1 %h", bus.cpu_ack, bus.cpu_rdata, ref_mem[13'h0777]); end
    bus.cpu_req = 1'b0;
    tick(); tick();
    checks++; if (bus.starve !== 1'b1) begin errors++; $display("FAIL starve_sticky got %b want 1", bus.starve); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_memory_image();
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    checks++; if (mism != 0) begin
      errors++; $display("FAIL mem_image got %0d differing bytes want 0", mism); end
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_byte(i);
    init_mem = 1'b1;
    @(posedge clk_pixel);
    #1;
    init_mem = 1'b0;
    test_reset();
    test_video();
    test_cpu_write_read();
    test_cpu_with_video();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_starve();
    test_memory_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
